// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with credit-limited memory requests, 2-entry output queue and redirect flush
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_j_valid,
    input  logic [31:0] next_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    logic [31:0] fetch_pc;
    logic [1:0]  inflight, discard, count;
    logic [31:0] tag_q [2];
    logic [31:0] word_q [2];
    logic [31:0] pc_q [2];
    logic        tag_wp, tag_rp, out_wp, out_rp;
    logic        fire, push, pop;

    // Request credit covers both in-flight words and buffered words, so out_q can never overflow
    always_comb begin
        imem_req_valid = !rst && !pc_j_valid && ({1'b0, inflight} + {1'b0, count} < 3'd2);
        imem_req_addr  = fetch_pc;
        fire           = imem_req_valid && imem_req_ready;
        instr_valid    = count != 2'd0;
        push           = imem_resp_valid && !pc_j_valid && discard == 2'd0;
        pop            = instr_valid && instr_ready && !pc_j_valid;
        instr          = word_q[out_rp];
        instr_pc       = pc_q[out_rp];
    end

    // Fetch PC, in-flight tag queue, discard counter and output queue; a redirect overrides pushes and pops
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 2'd0;
            discard  <= 2'd0;
            count    <= 2'd0;
            tag_wp   <= 1'b0;
            tag_rp   <= 1'b0;
            out_wp   <= 1'b0;
            out_rp   <= 1'b0;
            tag_q    <= '{default: 32'h0};
            word_q   <= '{default: 32'h0};
            pc_q     <= '{default: 32'h0};
        end else begin
            assert (!(push && count == 2'd2));
            if (fire) begin
                tag_q[tag_wp] <= fetch_pc;
                tag_wp        <= ~tag_wp;
                fetch_pc      <= fetch_pc + 32'd4;
            end
            if (imem_resp_valid) tag_rp <= ~tag_rp;
            inflight <= inflight + {1'b0, fire} - {1'b0, imem_resp_valid};
            if (pc_j_valid) begin
                // Every live in-flight word plus those already doomed becomes discard; a response now is dropped
                fetch_pc <= {next_pc[31:2], 2'b00};
                discard  <= inflight - {1'b0, imem_resp_valid};
                count    <= 2'd0;
                out_wp   <= 1'b0;
                out_rp   <= 1'b0;
            end else begin
                discard <= discard - {1'b0, imem_resp_valid && discard != 2'd0};
                if (push) begin
                    word_q[out_wp] <= imem_resp_data;
                    pc_q[out_wp]   <= tag_q[tag_rp];
                    out_wp         <= ~out_wp;
                end
                if (pop) out_rp <= ~out_rp;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end
endmodule
